// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: valid/ready handshake, 2-entry skid buffer,
// synchronous flush, bubble zeroing and transfer/stall statistics counters.
module pipe_stage_skid #(
    parameter int                 DATA_W  = 96,
    parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}},
    parameter int                 CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_main;
    logic [DATA_W-1:0]  r_skid;
    logic               r_out_valid;
    logic               r_in_ready;
    logic [CNT_W-1:0]   r_xfer;
    logic [CNT_W-1:0]   r_stall;

    logic               w_acc;
    logic               w_pop;

    assign w_acc = in_valid & r_in_ready;
    assign w_pop = r_out_valid & out_ready;

    // Stage FSM; handshake outputs are registered alongside the state they decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main      <= RST_VAL;
            r_skid      <= RST_VAL;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_main      <= RST_VAL;
            r_skid      <= RST_VAL;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_state     <= ST_FULL;
                        r_main      <= in_data;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_acc && w_pop) begin
                        r_main <= in_data;
                    end else if (w_pop) begin
                        r_state     <= ST_EMPTY;
                        r_main      <= RST_VAL;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end else if (w_acc) begin
                        // Downstream stalled: park the new word, drop ready next cycle
                        r_state    <= ST_SKID;
                        r_skid     <= in_data;
                        r_in_ready <= 1'b0;
                    end else begin
                        r_state <= ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (w_pop) begin
                        r_state    <= ST_FULL;
                        r_main     <= r_skid;
                        r_skid     <= RST_VAL;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_state <= ST_SKID;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_main      <= RST_VAL;
                    r_skid      <= RST_VAL;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Statistics counters; a pop in a flush cycle still counts, only rst clears them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer  <= {CNT_W{1'b0}};
            r_stall <= {CNT_W{1'b0}};
        end else begin
            if (w_pop) begin
                r_xfer <= r_xfer + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_xfer <= r_xfer;
            end
            if (r_out_valid && !out_ready) begin
                r_stall <= r_stall + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_stall <= r_stall;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign xfer_cnt  = r_xfer;
    assign stall_cnt = r_stall;

endmodule
